sabana_ez_vec_op: RTL and testbench

Parametrised streaming element-wise kernel.
- Pops one word from each of NUM_IN FWFT input queues, combines them with a run-time-selected operation, and pushes the result to one output queue.
- Runs for exactly len elements per start, then pulses finish.
- Sits between the host-managed input/output queues, in the same slot as the existing two-input adder kernel. It replaces that kernel with proper all-inputs/output-space gating, a registered output stage and count-based termination.

---
 rtl/sabana_ez_pkg.sv | 28 ++
 rtl/sabana_ez_alu.sv | 41 ++++
 rtl/sabana_ez_vec_op.sv | 98 +++++++++
 tb/tb_sabana_ez_vec_op.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sabana_ez_pkg.sv
// rtl/sabana_ez_pkg.sv - shared types for the sabana_ez vector kernel
//
// Purpose : operation and FSM state encodings shared by sabana_ez_vec_op
//           and its combinational fold unit sabana_ez_alu.
// Contents: OP_W (width of the op select), op_e, state_e.
package sabana_ez_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_MIN  = 3'd2,
    OP_MAX  = 3'd3,
    OP_AND  = 3'd4,
    OP_OR   = 3'd5,
    OP_XOR  = 3'd6,
    OP_RSVD = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sabana_ez_alu.sv
// rtl/sabana_ez_alu.sv - combinational left fold of NUM_IN words under op
//
// Purpose : result = in0 <op> in1 <op> ... <op> in(NUM_IN-1), modulo 2^WIDTH.
//           MIN/MAX compare as signed; OP_RSVD passes in0 unchanged.
// Ports   : op      - operation select
//           in_data - word i in bits [i*WIDTH +: WIDTH]
//           result  - folded word
module sabana_ez_alu
  import sabana_ez_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 2
) (
  input  op_e                       op,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  output logic [WIDTH-1:0]          result
);

  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] word;

  always_comb begin
    acc  = in_data[WIDTH-1:0];
    word = '0;
    for (int i = 1; i < NUM_IN; i++) begin
      word = in_data[i*WIDTH +: WIDTH];
      case (op)
        OP_ADD: acc = acc + word;
        OP_SUB: acc = acc - word;
        OP_MIN: acc = ($signed(word) < $signed(acc)) ? word : acc;
        OP_MAX: acc = ($signed(word) > $signed(acc)) ? word : acc;
        OP_AND: acc = acc & word;
        OP_OR:  acc = acc | word;
        OP_XOR: acc = acc ^ word;
        default: acc = acc;
      endcase
    end
    result = acc;
  end

endmodule

// File: rtl/sabana_ez_vec_op.sv
// rtl/sabana_ez_vec_op.sv - streaming element-wise kernel over NUM_IN FWFT queues
//
// Purpose : per start, pops len elements (one word from every input queue at
//           once), folds them under the latched op and pushes each result
//           through a single registered output stage, then pulses finish.
// Ports   : clock, reset     - rising-edge clock, synchronous active-high reset
//           start, len, op   - run request; len/op latched when accepted in IDLE
//           finish, busy     - end-of-run pulse / run in progress
//           in_data, in_empty, in_pop - heads, empty flags and pops of the input queues
//           y_out, y_push, y_full     - result word, push strobe, output queue full
module sabana_ez_vec_op
  import sabana_ez_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 2,
  parameter int LEN_W  = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [LEN_W-1:0]          len,
  input  logic [OP_W-1:0]           op,
  output logic                      finish,
  output logic                      busy,
  input  logic [NUM_IN*WIDTH-1:0]   in_data,
  input  logic [NUM_IN-1:0]         in_empty,
  output logic [NUM_IN-1:0]         in_pop,
  output logic [WIDTH-1:0]          y_out,
  output logic                      y_push,
  input  logic                      y_full
);

  state_e           state_q;
  op_e              op_q;
  logic [LEN_W-1:0] remaining_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] alu_result;
  logic             fire;

  sabana_ez_alu #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_alu (
    .op      (op_q),
    .in_data (in_data),
    .result  (alu_result)
  );

  // An element fires only when every queue has a head and the output
  // register is free or is being drained this same cycle.
  assign fire   = (state_q == RUN) && (remaining_q != '0) && (in_empty == '0)
                  && (!out_valid_q || !y_full);
  assign in_pop = {NUM_IN{fire}};
  assign y_push = out_valid_q & ~y_full;
  assign y_out  = out_data_q;
  assign finish = (state_q == DONE);
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= OP_ADD;
      remaining_q <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (fire) begin
        out_data_q  <= alu_result;
        out_valid_q <= 1'b1;
        remaining_q <= remaining_q - 1'b1;
      end else if (y_push) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            op_q        <= op_e'(op);
            remaining_q <= len;
            // A zero-length run passes through DRAIN (register already empty)
            // so finish lands two cycles after start.
            state_q     <= (len == '0) ? DRAIN : RUN;
          end
        end
        RUN: begin
          if (fire && remaining_q == LEN_W'(1)) state_q <= DRAIN;
        end
        DRAIN: begin
          // No fire in DRAIN, so a push this cycle empties the register.
          if (!out_valid_q || y_push) state_q <= DONE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sabana_ez_vec_op.sv
// tb/tb_sabana_ez_vec_op.sv - scoreboard bench for sabana_ez_vec_op
module tb_sabana_ez_vec_op;

  localparam int W  = 32;
  localparam int NI = 3;
  localparam int LW = 32;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            start = 1'b0;
  logic [LW-1:0]   len   = '0;
  logic [2:0]      op    = '0;
  logic            finish;
  logic            busy;
  logic [NI*W-1:0] in_data  = '0;
  logic [NI-1:0]   in_empty = '1;
  logic [NI-1:0]   in_pop;
  logic [W-1:0]    y_out;
  logic            y_push;
  logic            y_full = 1'b0;

  sabana_ez_vec_op #(.WIDTH(W), .NUM_IN(NI), .LEN_W(LW)) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .len      (len),
    .op       (op),
    .finish   (finish),
    .busy     (busy),
    .in_data  (in_data),
    .in_empty (in_empty),
    .in_pop   (in_pop),
    .y_out    (y_out),
    .y_push   (y_push),
    .y_full   (y_full)
  );

  always #5 clock = ~clock;

  logic [W-1:0]  in_q    [NI][$];
  logic [W-1:0]  stage_q [NI][$];
  logic [W-1:0]  exp_q   [$];
  logic [NI-1:0] starve     = '0;
  logic [NI-1:0] pend_pop   = '0;
  logic          rand_full  = 1'b0;
  logic          rand_feed  = 1'b0;
  logic          full_force = 1'b0;
  logic          prev_fin   = 1'b0;
  int compared = 0, mismatched = 0;
  int cyc = 0, push_cnt = 0, pop_cnt = 0, fin_cnt = 0;
  int last_push_cyc = -10, fin_cyc = -10;

  task automatic check(string name, logic [W-1:0] act, logic [W-1:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: left fold of the element's words under the operation.
  function automatic logic [W-1:0] ref_op(int o, logic [W-1:0] v [NI]);
    longint acc;
    int     m;
    logic [W-1:0] r;
    case (o)
      0: begin acc = 0; foreach (v[i]) acc += longint'(v[i]); r = acc[W-1:0]; end
      1: begin acc = longint'(v[0]); for (int i = 1; i < NI; i++) acc -= longint'(v[i]); r = acc[W-1:0]; end
      2: begin m = int'(v[0]); foreach (v[i]) if (int'(v[i]) < m) m = int'(v[i]); r = $unsigned(m); end
      3: begin m = int'(v[0]); foreach (v[i]) if (int'(v[i]) > m) m = int'(v[i]); r = $unsigned(m); end
      4: begin r = '1; foreach (v[i]) r &= v[i]; end
      5: begin r = '0; foreach (v[i]) r |= v[i]; end
      6: begin r = '0; foreach (v[i]) r ^= v[i]; end
      default: r = v[0];
    endcase
    return r;
  endfunction

  task automatic add_elem(int o, logic [W-1:0] v [NI], bit expect_it, bit staged);
    for (int i = 0; i < NI; i++) begin
      if (staged) stage_q[i].push_back(v[i]);
      else        in_q[i].push_back(v[i]);
    end
    if (expect_it) exp_q.push_back(ref_op(o, v));
  endtask

  task automatic flush();
    for (int i = 0; i < NI; i++) begin
      in_q[i].delete();
      stage_q[i].delete();
    end
  endtask

  // Queue side: apply pops seen last cycle, feed, then present heads.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      for (int i = 0; i < NI; i++)
        if (pend_pop[i] && in_q[i].size() > 0) void'(in_q[i].pop_front());
      if (rand_feed)
        for (int i = 0; i < NI; i++)
          if (stage_q[i].size() > 0 && $urandom_range(3) != 0)
            in_q[i].push_back(stage_q[i].pop_front());
      y_full <= rand_full ? ($urandom_range(2) == 0) : full_force;
      for (int i = 0; i < NI; i++) begin
        in_empty[i] <= starve[i] || (in_q[i].size() == 0);
        in_data[i*W +: W] <= (in_q[i].size() > 0) ? in_q[i][0] : '0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    forever begin
      @(negedge clock);
      pend_pop = in_pop;
      if (!reset) begin
        if (in_pop != '0) begin
          pop_cnt++;
          check("pop_all_queues", W'(in_pop), W'({NI{1'b1}}));
          check("pop_only_when_nonempty", W'(in_empty), '0);
        end
        if (y_push) begin
          push_cnt++;
          last_push_cyc = cyc;
          compared++;
          if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_push: got 0x%08h with no result outstanding (cycle %0d)", y_out, cyc);
          end else begin
            compared--;
            check("y_out", y_out, exp_q.pop_front());
          end
        end
        if (prev_fin) check("busy_after_finish", W'(busy), '0);
        if (finish) begin
          fin_cnt++;
          fin_cyc = cyc;
          check("busy_at_finish", W'(busy), W'(1));
        end
        prev_fin = finish;
      end
    end
  end

  task automatic do_start(int o, int n, output int s_cyc);
    @(posedge clock); #2;
    op = o[2:0]; len = n; start = 1'b1; s_cyc = cyc;
    @(posedge clock); #2;
    start = 1'b0;
  endtask

  task automatic wait_finish(int f0, int budget, string nm);
    int k = 0;
    while (fin_cnt == f0 && k < budget) begin
      @(posedge clock); #3;
      k++;
    end
    compared++;
    if (fin_cnt == f0) begin
      mismatched++;
      $display("FAIL %s_timeout: no finish within %0d cycles", nm, budget);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, f0, p0, q0, k;
    logic [W-1:0] v [NI];
    logic [W-1:0] a [4] = '{32'd1, 32'd2, 32'd3, 32'hFFFF_FFFF};
    logic [W-1:0] b [4] = '{32'd10, 32'd20, 32'd30, 32'd1};

    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", W'(busy), '0);
    check("rst_finish", W'(finish), '0);
    check("rst_in_pop", W'(in_pop), '0);
    check("rst_y_push", W'(y_push), '0);
    check("rst_y_out", y_out, '0);
    @(posedge clock); #2; reset = 1'b0;

    // ADD, full throughput.
    for (int i = 0; i < 4; i++) begin v = '{a[i], b[i], 32'd0}; add_elem(0, v, 1, 0); end
    f0 = fin_cnt; p0 = pop_cnt; q0 = push_cnt;
    do_start(0, 4, s);
    wait_finish(f0, 50, "add");
    check("add_pops", W'(pop_cnt - p0), W'(4));
    check("add_pushes", W'(push_cnt - q0), W'(4));
    check("add_finish_cycle", W'(fin_cyc - s), W'(6));
    check("add_finish_after_push", W'(fin_cyc), W'(last_push_cyc + 1));

    // Backpressure after the first push.
    for (int i = 0; i < 4; i++) begin v = '{a[i], b[i], 32'd0}; add_elem(0, v, 1, 0); end
    f0 = fin_cnt; q0 = push_cnt;
    do_start(0, 4, s);
    k = 0;
    while (push_cnt == q0 && k < 20) begin @(negedge clock); k++; end
    check("bp_first_push_seen", W'(push_cnt != q0), W'(1));
    full_force = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("bp_y_out_held", y_out, 32'd22);
      check("bp_no_pop", W'(in_pop), '0);
      check("bp_no_push", W'(y_push), '0);
    end
    full_force = 1'b0;
    wait_finish(f0, 50, "bp");
    check("bp_pushes", W'(push_cnt - q0), W'(4));
    check("bp_finish_after_push", W'(fin_cyc), W'(last_push_cyc + 1));

    // Starvation, SUB 7-3-1 with queue 2 hidden.
    starve = 3'b100;
    v = '{32'd7, 32'd3, 32'd1}; add_elem(1, v, 1, 0);
    f0 = fin_cnt; p0 = pop_cnt;
    do_start(1, 1, s);
    repeat (5) @(posedge clock);
    #2;
    check("starve_no_pops", W'(pop_cnt - p0), '0);
    starve = '0;
    wait_finish(f0, 50, "starve");
    check("starve_pops", W'(pop_cnt - p0), W'(1));

    // len == 0, second start while busy is ignored.
    v = '{32'd5, 32'd6, 32'd7}; add_elem(0, v, 0, 0);
    f0 = fin_cnt; p0 = pop_cnt; q0 = push_cnt;
    @(posedge clock); #2; op = 3'd0; len = 0; start = 1'b1; s = cyc;
    @(posedge clock); #2; len = 3;
    @(posedge clock); #2; start = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    check("len0_one_finish", W'(fin_cnt - f0), W'(1));
    check("len0_finish_cycle", W'(fin_cyc - s), W'(2));
    check("len0_no_pops", W'(pop_cnt - p0), '0);
    check("len0_no_pushes", W'(push_cnt - q0), '0);
    flush();

    // Signed MIN then MAX; op changes mid-run are ignored.
    v = '{32'h8000_0000, 32'd5, 32'h7FFF_FFFF}; add_elem(2, v, 1, 0);
    v = '{32'd9, 32'hFFFF_FFF0, 32'd3};         add_elem(2, v, 1, 0);
    f0 = fin_cnt;
    do_start(2, 2, s);
    op = 3'd3;
    wait_finish(f0, 50, "min");
    v = '{32'h8000_0000, 32'd5, 32'h8000_0000}; add_elem(3, v, 1, 0);
    f0 = fin_cnt;
    do_start(3, 1, s);
    op = 3'd2;
    wait_finish(f0, 50, "max");

    // Reset after 2 of 6 elements (queue 2 holds only two).
    for (int i = 0; i < 2; i++) begin v = '{W'(i + 1), W'(i + 100), W'(i + 7)}; add_elem(0, v, 1, 0); end
    for (int i = 0; i < 4; i++) begin in_q[0].push_back(W'(50 + i)); in_q[1].push_back(W'(60 + i)); end
    p0 = pop_cnt; q0 = push_cnt;
    do_start(0, 6, s);
    repeat (8) @(posedge clock);
    #2;
    check("rst_mid_pops", W'(pop_cnt - p0), W'(2));
    check("rst_mid_pushes", W'(push_cnt - q0), W'(2));
    reset = 1'b1;
    @(posedge clock); #2; reset = 1'b0;
    @(negedge clock);
    check("rst_mid_busy", W'(busy), '0);
    check("rst_mid_in_pop", W'(in_pop), '0);
    check("rst_mid_y_push", W'(y_push), '0);
    check("rst_mid_y_out", y_out, '0);
    check("rst_mid_finish", W'(finish), '0);
    check("rst_mid_q0_left", W'(in_q[0].size()), W'(4));
    check("rst_mid_q1_left", W'(in_q[1].size()), W'(4));
    flush();
    v = '{32'hA5A5_0000, 32'h0000_5A5A, 32'h1234_5678}; add_elem(6, v, 1, 0);
    f0 = fin_cnt;
    do_start(6, 1, s);
    wait_finish(f0, 50, "post_reset");

    // Randomized runs with trickle-fed queues and random backpressure.
    rand_full = 1'b1;
    rand_feed = 1'b1;
    for (int r = 0; r < 10; r++) begin
      int o, n;
      o = $urandom_range(7);
      n = $urandom_range(12, 1);
      for (int e = 0; e < n + 2; e++) begin
        for (int i = 0; i < NI; i++) v[i] = $urandom;
        add_elem(o, v, e < n, 1);
      end
      f0 = fin_cnt; q0 = push_cnt;
      do_start(o, n, s);
      wait_finish(f0, 400, "rand");
      check("rand_pushes", W'(push_cnt - q0), W'(n));
      check("rand_finish_after_push", W'(fin_cyc), W'(last_push_cyc + 1));
      for (int i = 0; i < NI; i++)
        check("rand_extra_not_popped", W'(in_q[i].size() + stage_q[i].size()), W'(2));
      flush();
    end
    rand_full = 1'b0;
    rand_feed = 1'b0;
    repeat (3) @(posedge clock);
    #2;
    check("scoreboard_drained", W'(exp_q.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
